// File: rtl/key_scan_pkg.sv
// Shared definitions for the key matrix scanner.
// Contents: matrix geometry, event word width, scan FSM state type and a helper
// that forms a key code from a column/row pair.
package key_scan_pkg;

  localparam int unsigned NUM_COLS   = 4;
  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned NUM_KEYS   = NUM_COLS * NUM_ROWS;
  localparam int unsigned KEY_CODE_W = 4;
  // Event word: {key_code, press}
  localparam int unsigned EVT_W      = KEY_CODE_W + 1;

  typedef enum logic {
    StIdle,
    StEmit
  } scan_state_e;

  // Key code is col*4+row, i.e. {col, row}.
  function automatic logic [KEY_CODE_W-1:0] key_index(input logic [1:0] col,
                                                      input logic [1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small event buffer between the scanner and the consumer.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset
//   push_i   write data_i (ignored when full unless pop_i is also high)
//   data_i   event word in
//   pop_i    remove head entry (ignored when empty)
//   full_o   Depth entries held
//   empty_o  no entries held
//   data_o   head entry, stable until popped
// Push and pop in the same cycle while full is legal: the head leaves and the new
// word takes the freed slot.
module key_event_fifo #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntOne;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 push-button matrix scanner with per-key debounce and press/release events.
// One column is driven low per dwell period; the active-low rows are synchronized,
// sampled on the last dwell cycle and walked one row per cycle to update the
// debounced key map and emit events over a valid/ready interface.
// Ports:
//   clk12MHz   system clock
//   reset      asynchronous active-high reset
//   krow       matrix rows, active-low, asynchronous
//   kcol       column drive, one-hot active-low, registered
//   keys       debounced key state, 1 = pressed, index col*4+row
//   evt_valid  event available
//   evt_ready  consumer accepts when evt_valid & evt_ready
//   evt_code   key code {col, row}
//   evt_press  1 = press, 0 = release
//   overflow   sticky, an event was dropped
//   ovf_clr    clears overflow (a same-cycle drop wins)
// Configuration: define KEY_SCAN_EVENT_FIFO_EN for a 4-entry event queue;
// otherwise a single holding register is used.
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_BITS = 16,
  parameter int unsigned DEB_COUNT = 3
) (
  input  logic                  clk12MHz,
  input  logic                  reset,
  input  logic [NUM_ROWS-1:0]   krow,
  output logic [NUM_COLS-1:0]   kcol,
  output logic [NUM_KEYS-1:0]   keys,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [KEY_CODE_W-1:0] evt_code,
  output logic                  evt_press,
  output logic                  overflow,
  input  logic                  ovf_clr
);

`ifdef KEY_SCAN_EVENT_FIFO_EN
  localparam int unsigned EvtDepth = 4;
`else
  localparam int unsigned EvtDepth = 1;
`endif

  localparam logic [SCAN_BITS-1:0] TimerOne = SCAN_BITS'(1);
  localparam logic [1:0]           DebLast  = 2'(DEB_COUNT - 1);

  logic [SCAN_BITS-1:0] timer_q, timer_d;
  logic [NUM_COLS-1:0]  kcol_q, kcol_d;
  logic [NUM_ROWS-1:0]  sync1_q, sync2_q;
  logic [NUM_ROWS-1:0]  sample_q, sample_d;
  logic [1:0]           scol_q, scol_d;
  logic [1:0]           row_q, row_d;
  scan_state_e          state_q, state_d;
  logic [NUM_KEYS-1:0]  keys_q, keys_d;
  logic [1:0]           cnt_q [NUM_KEYS];
  logic [1:0]           cnt_d [NUM_KEYS];
  logic                 ovf_q, ovf_d;

  logic [1:0]            scan_col;
  logic                  dwell_end;
  logic [KEY_CODE_W-1:0] cur_key;
  logic                  cur_bit;
  logic                  push_evt;
  logic [EVT_W-1:0]      push_data;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [EVT_W-1:0]      fifo_dout;

  assign scan_col  = timer_q[SCAN_BITS-1 -: 2];
  assign dwell_end = &timer_q[SCAN_BITS-3:0];

  assign fifo_pop  = evt_valid & evt_ready;
  // A push into a full buffer survives only if the head leaves in the same cycle.
  assign drop      = push_evt & fifo_full & ~fifo_pop;
  assign fifo_push = push_evt & ~drop;

  always_comb begin
    timer_d   = timer_q + TimerOne;
    kcol_d    = ~(4'b0001 << scan_col);
    sample_d  = sample_q;
    scol_d    = scol_q;
    row_d     = row_q;
    state_d   = state_q;
    keys_d    = keys_q;
    cnt_d     = cnt_q;
    cur_key   = key_index(scol_q, row_q);
    cur_bit   = sample_q[row_q];
    push_evt  = 1'b0;
    push_data = '0;

    unique case (state_q)
      StIdle: begin
        if (dwell_end) begin
          sample_d = ~sync2_q;
          scol_d   = scan_col;
          row_d    = 2'd0;
          state_d  = StEmit;
        end
      end
      StEmit: begin
        if (cur_bit == keys_q[cur_key]) begin
          cnt_d[cur_key] = 2'd0;
        end else if (cnt_q[cur_key] == DebLast) begin
          keys_d[cur_key] = cur_bit;
          cnt_d[cur_key]  = 2'd0;
          push_evt        = 1'b1;
          push_data       = {cur_key, cur_bit};
        end else begin
          cnt_d[cur_key] = cnt_q[cur_key] + 2'd1;
        end
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      timer_q  <= '0;
      kcol_q   <= 4'b1110;
      sync1_q  <= '1;
      sync2_q  <= '1;
      sample_q <= '0;
      scol_q   <= '0;
      row_q    <= '0;
      state_q  <= StIdle;
      keys_q   <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q    <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      kcol_q   <= kcol_d;
      sync1_q  <= krow;
      sync2_q  <= sync1_q;
      sample_q <= sample_d;
      scol_q   <= scol_d;
      row_q    <= row_d;
      state_q  <= state_d;
      keys_q   <= keys_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  key_event_fifo #(
    .Depth (EvtDepth),
    .Width (EVT_W)
  ) u_evt_fifo (
    .clk_i   (clk12MHz),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (fifo_dout)
  );

  assign kcol      = kcol_q;
  assign keys      = keys_q;
  assign evt_valid = ~fifo_empty;
  assign evt_code  = fifo_dout[EVT_W-1:1];
  assign evt_press = fifo_dout[0];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan with SCAN_BITS=6 (16-cycle dwell, 64-cycle scan),
// DEB_COUNT=3. A matrix model pulls rows low for pressed keys in the driven column.
// The reference model counts consecutive differing column samples per key and
// predicts the debounced map and the ordered event stream.
module tb_key_matrix_scan;

  localparam int DEB = 3;
`ifdef KEY_SCAN_EVENT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk12MHz = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  krow;
  logic [3:0]  kcol;
  logic [15:0] keys;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [3:0]  evt_code;
  logic        evt_press;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  key_matrix_scan #(
    .SCAN_BITS (6),
    .DEB_COUNT (3)
  ) dut (
    .clk12MHz  (clk12MHz),
    .reset     (reset),
    .krow      (krow),
    .kcol      (kcol),
    .keys      (keys),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk12MHz = ~clk12MHz;

  logic [15:0] pressed = '0;

  always_comb begin
    krow = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && (kcol[c] === 1'b0)) krow[r] = 1'b0;
      end
    end
  end

  // Reference model state
  logic [15:0] mkeys;
  int          mcnt [16];
  logic        movf;
  logic [4:0]  exp_q [$];
  int          acc_t [$];
  logic [4:0]  last_evt;
  int          tcnt, n_acc, n_checks, n_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    mkeys = '0;
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    movf = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_sample(input int c);
    for (int r = 0; r < 4; r++) begin
      int  k;
      logic s;
      k = c * 4 + r;
      s = pressed[k];
      if (s == mkeys[k]) begin
        mcnt[k] = 0;
      end else begin
        mcnt[k]++;
        if (mcnt[k] == DEB) begin
          mkeys[k] = s;
          mcnt[k]  = 0;
          if (!evt_ready && exp_q.size() >= DEPTH) movf = 1'b1;
          else exp_q.push_back({4'(k), s});
        end
      end
    end
  endtask

  // One clock: observe handshake before the edge, advance, update model after it.
  task automatic cycle();
    if (exp_q.size() == 0) begin
      n_checks++;
      assert (evt_valid === 1'b0) else begin
        n_errs++;
        $error("FAIL evt_spurious: valid=%b code=%0d expected no event", evt_valid, evt_code);
      end
    end
    if (evt_valid === 1'b1 && evt_ready) begin
      n_acc++;
      acc_t.push_back(tcnt);
      last_evt = {evt_code, evt_press};
      if (exp_q.size() > 0) begin
        logic [4:0] e;
        e = exp_q.pop_front();
        n_checks++;
        assert ({evt_code, evt_press} === e) else begin
          n_errs++;
          $error("FAIL evt_data: got code=%0d press=%0d expected code=%0d press=%0d",
                 evt_code, evt_press, e[4:1], e[0]);
        end
      end
    end
    @(posedge clk12MHz);
    tcnt++;
    @(negedge clk12MHz);
    if (tcnt % 16 == 0) model_sample(((tcnt / 16) + 3) % 4);
    if (tcnt % 16 == 8) chk("keys_map", 32'(keys), 32'(mkeys));
  endtask

  task automatic scans(input int n);
    for (int i = 0; i < n * 64; i++) cycle();
  endtask

  task automatic to_scan_start();
    while (tcnt % 64 != 0) cycle();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pressed = '0;
    model_clear();
    acc_t.delete();
    repeat (2) @(negedge clk12MHz);
    reset = 1'b0;
    tcnt  = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_kcol"}, 32'(kcol), 32'h0000_000E);
    chk({tag, "_keys"}, 32'(keys), 32'h0);
    chk({tag, "_valid"}, 32'(evt_valid), 32'h0);
    chk({tag, "_code"}, 32'(evt_code), 32'h0);
    chk({tag, "_press"}, 32'(evt_press), 32'h0);
    chk({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  function automatic int acc_at(input int i);
    return (acc_t.size() > i) ? acc_t[i] : -1;
  endfunction

  initial begin
    int base, n0;
    n_checks = 0;
    n_errs   = 0;
    n_acc    = 0;
    last_evt = '0;
    do_reset();
    chk_reset_state("rst0");

    // Key 5 held for 4 scans, then released for 3.
    base = tcnt;
    n0 = n_acc;
    acc_t.delete();
    pressed = 16'h0020;
    scans(2);
    chk("k5_after2", 32'(keys[5]), 32'h0);
    scans(1);
    chk("k5_after3", 32'(keys[5]), 32'h1);
    chk("k5_press_time", 32'(acc_at(0)), 32'(base + 128 + 34));
    chk("k5_press_evt", 32'(last_evt), 32'({4'd5, 1'b1}));
    scans(1);
    chk("k5_press_count", 32'(n_acc - n0), 32'd1);
    pressed = '0;
    scans(3);
    chk("k5_rel_count", 32'(n_acc - n0), 32'd2);
    chk("k5_rel_evt", 32'(last_evt), 32'({4'd5, 1'b0}));
    chk("k5_rel_keys", 32'(keys), 32'h0);

    // Bounce: 2 pressed, 1 released, 2 pressed, 1 released.
    n0 = n_acc;
    pressed = 16'h0020; scans(2);
    pressed = '0;       scans(1);
    pressed = 16'h0020; scans(2);
    pressed = '0;       scans(1);
    chk("bounce_count", 32'(n_acc - n0), 32'd0);
    chk("bounce_keys", 32'(keys), 32'h0);

    // Whole column 2 together: four events on consecutive cycles.
    base = tcnt;
    acc_t.delete();
    pressed = 16'h0F00;
    scans(3);
    chk("col2_count", 32'(acc_t.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("col2_time", 32'(acc_at(i)), 32'(base + 128 + 49 + i));
    chk("col2_last", 32'(last_evt), 32'({4'd11, 1'b1}));
    chk("col2_keys", 32'(keys), 32'h0F00);
    pressed = '0;
    scans(3);
    chk("col2_rel_keys", 32'(keys), 32'h0);

    // Consumer stalled, keys 0 and 1 pressed.
    evt_ready = 1'b0;
    pressed = 16'h0003;
    scans(3);
    chk("stall_valid", 32'(evt_valid), 32'h1);
    chk("stall_code", 32'(evt_code), 32'h0);
    chk("stall_press", 32'(evt_press), 32'h1);
    chk("stall_ovf", 32'(overflow), (DEPTH == 1) ? 32'h1 : 32'h0);
    chk("stall_ovf_model", 32'(overflow), 32'(movf));
    chk("stall_keys", 32'(keys), 32'h0003);
    n0 = n_acc;
    evt_ready = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    chk("stall_drained", 32'(n_acc - n0), (DEPTH == 1) ? 32'd1 : 32'd2);
    chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // Overflow clear with no concurrent drop.
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    movf = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'h0);
    to_scan_start();
    pressed = '0;
    scans(3);
    chk("rel01_keys", 32'(keys), 32'h0);

    // Drop coinciding with ovf_clr: set wins.
    base = tcnt;
    evt_ready = 1'b0;
    pressed = 16'h00FF;
    for (int i = 0; i < 160; i++) cycle();
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'h1);
    chk("ovf_model", 32'(movf), 32'h1);
    for (int i = 0; i < 4; i++) cycle();
    chk("pre_rst_valid", 32'(evt_valid), 32'h1);
    chk("pre_rst_keys", 32'(keys), 32'h00FF);

    // Asynchronous reset mid-dwell while an event is pending.
    #2 reset = 1'b1;
    #1;
    chk_reset_state("rst_async");
    do_reset();
    evt_ready = 1'b1;
    chk_reset_state("rst1");

    // Random key patterns, consumer always ready.
    for (int s = 0; s < 16; s++) begin
      if ($urandom_range(0, 2) == 0) pressed = 16'($urandom);
      scans(1);
    end
    pressed = '0;
    scans(3);
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_ovf", 32'(overflow), 32'h0);
    chk("rand_keys", 32'(keys), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
